// File: rtl/fmlmem_if.sv
// FML bus bundle between a master and the fmlmem responder.
interface fmlmem_if #(
    parameter int fml_depth = 26
);
    logic [fml_depth-1:0] fml_adr;
    logic                 fml_stb;
    logic                 fml_we;
    logic                 fml_eack;
    logic [7:0]           fml_sel;
    logic [63:0]          fml_di;
    logic [63:0]          fml_do;

    modport master (
        output fml_adr, fml_stb, fml_we, fml_sel, fml_di,
        input  fml_eack, fml_do
    );

    modport slave (
        input  fml_adr, fml_stb, fml_we, fml_sel, fml_di,
        output fml_eack, fml_do
    );
endinterface

// File: rtl/fmlmem.sv
// FML burst responder backed by a line-organised 64-bit synchronous RAM.
module fmlmem #(
    parameter int fml_depth      = 26,
    parameter int mem_lines_log2 = 8,
    parameter int read_latency   = 4
) (
    input logic     sys_clk,
    input logic     sys_rst_n,
    fmlmem_if.slave fml
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WRITE  = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;
    localparam logic [1:0] RDDATA = 2'd3;

    localparam int         AW       = mem_lines_log2 + 2;
    localparam logic [2:0] LAT_INIT = 3'(read_latency - 2);

    logic [1:0]                state_q, state_d;
    logic [1:0]                beat_q, beat_d;
    logic [2:0]                lat_q, lat_d;
    logic [mem_lines_log2-1:0] line_q, line_d;
    logic [63:0]               do_q;
    logic                      eack;
    logic                      wr_en;
    logic                      rd_en;
    logic [63:0]               mem [2**AW];

    // Only the line-index bits of the address matter; the rest alias.
    logic unused_adr;
    assign unused_adr = ^fml.fml_adr;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        line_d  = line_q;
        rd_en   = 1'b0;
        eack    = sys_rst_n && (state_q == IDLE) && fml.fml_stb;
        wr_en   = sys_rst_n && (state_q == WRITE);
        case (state_q)
            IDLE: begin
                if (eack) begin
                    line_d  = fml.fml_adr[mem_lines_log2+4:5];
                    beat_d  = 2'd0;
                    lat_d   = LAT_INIT;
                    state_d = fml.fml_we ? WRITE : RDWAIT;
                end
            end
            WRITE: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3)
                    state_d = IDLE;
            end
            RDWAIT: begin
                // RAM read lands in do_q one cycle later, so beat 0 is fetched in the last wait cycle.
                if (lat_q == 3'd0) begin
                    rd_en   = 1'b1;
                    beat_d  = 2'd1;
                    state_d = RDDATA;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: begin
                // beat_q wraps to 0 while beat 3 is on the bus: that is the final data cycle.
                if (beat_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    rd_en  = 1'b1;
                    beat_d = beat_q + 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            lat_q   <= 3'd0;
            line_q  <= '0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            line_q  <= line_d;
            do_q    <= rd_en ? mem[{line_q, beat_q}] : '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (fml.fml_sel[i])
                    mem[{line_q, beat_q}][8*i +: 8] <= fml.fml_di[8*i +: 8];
            end
        end
    end

    assign fml.fml_eack = eack;
    assign fml.fml_do   = do_q;
endmodule

// File: tb/tb_fmlmem.sv
// Randomised bench for fmlmem: per-cycle compare against a transaction-level memory model.
module tb_fmlmem;
    localparam int L = 4;

    logic sys_clk;
    logic sys_rst_n;

    fmlmem_if #(.fml_depth(26)) fml ();

    fmlmem #(
        .fml_depth(26),
        .mem_lines_log2(8),
        .read_latency(L)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .fml(fml)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    logic [63:0] m [1024];
    logic        exp_eack;
    logic [63:0] exp_do;
    logic        lit_en;
    logic [63:0] lit_val;
    logic        check_en;
    int          total;
    int          bad;

    always @(negedge sys_clk) begin
        if (check_en) begin
            total++;
            if (fml.fml_eack !== exp_eack) begin
                bad++;
                $display("FAIL eack t=%0t got=%b want=%b", $time, fml.fml_eack, exp_eack);
            end
            total++;
            if (fml.fml_do !== exp_do) begin
                bad++;
                $display("FAIL do t=%0t got=%h want=%h", $time, fml.fml_do, exp_do);
            end
            if (lit_en) begin
                total++;
                if (fml.fml_do !== lit_val) begin
                    bad++;
                    $display("FAIL lit t=%0t got=%h want=%h", $time, fml.fml_do, lit_val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic int lidx(input logic [25:0] a);
        return (int'(a) >> 5) % 256;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int j = 0; j < 8; j++)
            if (s[j]) r[8*j +: 8] = nw[8*j +: 8];
        return r;
    endfunction

    function automatic logic [25:0] mkadr(input logic [7:0] line);
        return {13'($urandom), line, 5'($urandom)};
    endfunction

    task automatic junk(input bit hold);
        fml.fml_stb = hold ? 1'b1 : 1'($urandom_range(0, 1));
        fml.fml_we  = 1'($urandom);
        fml.fml_adr = 26'($urandom);
        fml.fml_di  = {$urandom, $urandom};
        fml.fml_sel = 8'($urandom);
    endtask

    task automatic idle();
        junk(1'b0);
        fml.fml_stb = 1'b0;
        exp_eack = 1'b0;
        exp_do   = '0;
        lit_en   = 1'b0;
        tick();
    endtask

    task automatic reset_cycle();
        junk(1'b1);
        sys_rst_n = 1'b0;
        exp_eack  = 1'b0;
        exp_do    = '0;
        lit_en    = 1'b0;
        tick();
        sys_rst_n = 1'b1;
    endtask

    task automatic wr_burst(input logic [25:0] a, input logic [63:0] d [4],
                            input logic [7:0] s [4], input bit hold, input int rst_at);
        int idx;
        idx = lidx(a);
        junk(hold);
        fml.fml_adr = a;
        fml.fml_stb = 1'b1;
        fml.fml_we  = 1'b1;
        exp_eack = 1'b1;
        exp_do   = '0;
        lit_en   = 1'b0;
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (c == rst_at) begin
                reset_cycle();
                return;
            end
            junk(hold);
            fml.fml_di  = d[c-1];
            fml.fml_sel = s[c-1];
            exp_eack = 1'b0;
            tick();
            m[idx*4 + c - 1] = merge(m[idx*4 + c - 1], d[c-1], s[c-1]);
        end
    endtask

    task automatic rd_burst(input logic [25:0] a, input bit hold, input int rst_at,
                            input bit use_lit, input logic [63:0] lit [4]);
        int idx;
        idx = lidx(a);
        junk(hold);
        fml.fml_adr = a;
        fml.fml_stb = 1'b1;
        fml.fml_we  = 1'b0;
        exp_eack = 1'b1;
        exp_do   = '0;
        lit_en   = 1'b0;
        tick();
        for (int c = 1; c <= L + 3; c++) begin
            if (c == rst_at) begin
                reset_cycle();
                return;
            end
            junk(hold);
            exp_eack = 1'b0;
            if (c >= L) begin
                exp_do  = m[idx*4 + c - L];
                lit_en  = use_lit;
                lit_val = lit[c-L];
            end else begin
                exp_do = '0;
                lit_en = 1'b0;
            end
            tick();
        end
    endtask

    logic [63:0] d28 [4];
    logic [63:0] dw  [4];
    logic [63:0] lit [4];
    logic [63:0] nolit [4];
    logic [7:0]  sff [4];
    logic [7:0]  sw  [4];
    logic [7:0]  pool [6];

    initial begin
        total    = 0;
        bad      = 0;
        check_en = 1'b0;
        lit_en   = 1'b0;
        exp_eack = 1'b0;
        exp_do   = '0;
        lit_val  = '0;
        nolit    = '{default: '0};
        sff      = '{default: 8'hFF};
        pool     = '{8'h20, 8'h40, 8'h00, 8'hFF, 8'h7E, 8'h13};
        d28      = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                     64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        sys_rst_n   = 1'b0;
        fml.fml_stb = 1'b1;
        fml.fml_we  = 1'b0;
        fml.fml_adr = '0;
        fml.fml_sel = '0;
        fml.fml_di  = '0;
        tick();
        check_en = 1'b1;
        tick();
        sys_rst_n = 1'b1;
        idle();

        // basic write then read of line 0x20
        wr_burst(26'h400, d28, sff, 1'b0, 0);
        rd_burst(26'h400, 1'b0, 0, 1'b1, d28);
        idle();

        // partial byte-lane write over a known word
        dw = '{64'h0, 64'h1111_1111_2222_2222, 64'h0, 64'h0};
        wr_burst(26'h800, dw, sff, 1'b0, 0);
        dw = '{64'hDEAD_BEEF_DEAD_BEEF, 64'hAAAA_AAAA_BBBB_BBBB,
               64'hCAFE_CAFE_CAFE_CAFE, 64'h5555_5555_5555_5555};
        sw = '{8'h00, 8'h0F, 8'h00, 8'h00};
        wr_burst(26'h800, dw, sw, 1'b0, 0);
        lit = '{64'h0, 64'h1111_1111_BBBB_BBBB, 64'h0, 64'h0};
        rd_burst(26'h800, 1'b0, 0, 1'b1, lit);
        idle();

        // aliasing upper bits and ignored low bits
        rd_burst(26'h241F, 1'b0, 0, 1'b1, d28);
        idle();

        // strobe held high with back-to-back write/read/write
        dw = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
               64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
        wr_burst(26'h40F, dw, sff, 1'b1, 0);
        rd_burst(26'h400, 1'b1, 0, 1'b1, dw);
        wr_burst(26'h400, d28, sff, 1'b1, 0);
        idle();

        // reset mid-write: only beat 0 lands
        dw = '{64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888,
               64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666};
        wr_burst(26'h400, dw, sff, 1'b0, 2);
        lit = '{64'h9999_9999_9999_9999, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        rd_burst(26'h400, 1'b0, 0, 1'b1, lit);
        idle();

        // reset mid-read: no beats, then eack on the first released cycle
        rd_burst(26'h400, 1'b1, 3, 1'b0, nolit);
        rd_burst(26'h400, 1'b0, 0, 1'b1, lit);
        idle();

        for (int p = 0; p < 6; p++) begin
            for (int b = 0; b < 4; b++) dw[b] = {$urandom, $urandom};
            wr_burst(mkadr(pool[p]), dw, sff, 1'b0, 0);
        end

        for (int n = 0; n < 80; n++) begin
            logic [25:0] a;
            a = mkadr(pool[$urandom_range(0, 5)]);
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 4; b++) begin
                    dw[b] = {$urandom, $urandom};
                    sw[b] = 8'($urandom);
                end
                wr_burst(a, dw, sw, 1'($urandom), 0);
            end else begin
                rd_burst(a, 1'($urandom), 0, 1'b0, nolit);
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) idle();
        end

        idle();
        idle();
        @(negedge sys_clk);
        #1;
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
